cp0_unit: RTL and testbench

Coprocessor-0 for the P7 MIPS core; sits directly downstream of the timer/device IRQ lines.
- Latches hardware interrupt requests (timer IRQs on hwint_i[1:0], external on [2]) and synchronous exception codes from the M stage.
- Decides whether to trap this cycle and records SR/Cause/EPC state.
- Provides mfc0/mtc0 access and eret return.

---
 rtl/cp0_unit.sv | 163 ++++++++++++++++
 tb/tb_cp0_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit -- Coprocessor 0 for the P7 MIPS core.
//
// Latches hardware interrupt lines and M-stage synchronous exceptions, decides
// whether to trap in the current cycle, keeps SR/Cause/EPC state, and serves
// mfc0/mtc0 accesses and eret.
//
// Optional build macro: CP0_BADVADDR_EN
//   When defined, adds input badvaddr_i and a read-only BadVAddr register ($8)
//   loaded on address-error traps (ExcCode 4/5). When undefined, $8 reads 0.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   pc_i, bd_i     PC / delay-slot flag of the M-stage instruction
//   exc_valid_i    M-stage synchronous exception, code on exc_code_i
//   hwint_i        level-sensitive hardware interrupt lines
//   we_i, addr_i,  mtc0 write enable, CP0 register number, write data
//   wdata_i
//   eret_i         eret in M stage
//   badvaddr_i     faulting address (CP0_BADVADDR_EN builds only)
//   rdata_o        mfc0 read data (pre-edge register values)
//   req_o          trap this cycle: flush and redirect to vec_o
//   vec_o          handler entry address
//   epc_o          eret return address (bypasses a same-cycle mtc0 EPC)
//   exl_o          SR.EXL
// -----------------------------------------------------------------------------
module cp0_unit #(
   parameter logic [31:0] PRID    = 32'h4D495053,
   parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   input  logic        bd_i,
   input  logic        exc_valid_i,
   input  logic [4:0]  exc_code_i,
   input  logic [5:0]  hwint_i,
   input  logic        we_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] wdata_i,
   input  logic        eret_i,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0] badvaddr_i,
`endif
   output logic [31:0] rdata_o,
   output logic        req_o,
   output logic [31:0] vec_o,
   output logic [31:0] epc_o,
   output logic        exl_o
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;
`ifdef CP0_BADVADDR_EN
   localparam logic [4:0] ADDR_BADVA = 5'd8;
`endif

   // Architectural state
   logic [5:0]  im_reg;
   logic        exl_reg;
   logic        ie_reg;
   logic        bd_reg;
   logic [5:0]  ip_reg;
   logic [4:0]  exc_code_reg;
   logic [31:0] epc_reg;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_reg;
`endif

   logic [5:0]  pending;
   logic        int_req;
   logic        exc_req;
   logic [31:0] pc_aligned;
   logic [31:0] epc_trap;
   logic [31:0] epc_write;

   // Low PC bits never reach EPC (it is always word-aligned).
   logic unused_pc;
   assign unused_pc = ^pc_i[1:0];

   // Per-line enabled interrupt requests; hwint_i is used directly so an
   // interrupt traps in the same cycle it is raised.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_pending
         assign pending[gi] = hwint_i[gi] & im_reg[gi];
      end
   endgenerate

   assign int_req = (|pending) & ie_reg & ~exl_reg;
   assign exc_req = exc_valid_i & ~exl_reg;
   assign req_o   = int_req | exc_req;

   assign pc_aligned = {pc_i[31:2], 2'b00};
   // A faulting delay-slot instruction restarts at its branch.
   assign epc_trap   = bd_i ? (pc_aligned - 32'd4) : pc_aligned;
   assign epc_write  = {wdata_i[31:2], 2'b00};

   assign vec_o = EXC_VEC;
   assign exl_o = exl_reg;
   // Same-cycle mtc0 EPC is forwarded so an immediately following eret
   // returns to the freshly written address.
   assign epc_o = (we_i && addr_i == ADDR_EPC) ? epc_write : epc_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ip_reg       <= '0;
         exc_code_reg <= '0;
         epc_reg      <= '0;
`ifdef CP0_BADVADDR_EN
         badvaddr_reg <= '0;
`endif
      end else begin
         ip_reg <= hwint_i;
         if (req_o) begin
            // Trap entry: any mtc0/eret in M this cycle is flushed.
            exl_reg      <= 1'b1;
            exc_code_reg <= int_req ? 5'd0 : exc_code_i;
            bd_reg       <= bd_i;
            epc_reg      <= epc_trap;
`ifdef CP0_BADVADDR_EN
            if (!int_req && (exc_code_i == 5'd4 || exc_code_i == 5'd5))
               badvaddr_reg <= badvaddr_i;
`endif
         end else begin
            if (eret_i)
               exl_reg <= 1'b0;
            if (we_i) begin
               case (addr_i)
                  ADDR_SR: begin
                     im_reg  <= wdata_i[15:10];
                     exl_reg <= wdata_i[1];
                     ie_reg  <= wdata_i[0];
                  end
                  ADDR_EPC: epc_reg <= epc_write;
                  default: ;
               endcase
            end
         end
      end
   end

   // mfc0 read mux: current register values, no write bypass.
   always_comb begin
      rdata_o = '0;
      case (addr_i)
         ADDR_SR:    rdata_o = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
         ADDR_CAUSE: rdata_o = {bd_reg, 15'd0, ip_reg, 3'd0, exc_code_reg, 2'd0};
         ADDR_EPC:   rdata_o = epc_reg;
         ADDR_PRID:  rdata_o = PRID;
`ifdef CP0_BADVADDR_EN
         ADDR_BADVA: rdata_o = badvaddr_reg;
`endif
         default:    rdata_o = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_unit -- self-checking bench for cp0_unit.
// A table of per-cycle vectors (inputs plus expected combinational outputs in
// that cycle) covers the normal flows; short hand-written sequences cover
// reset during EXL and, when CP0_BADVADDR_EN is defined, BadVAddr capture.
// -----------------------------------------------------------------------------
module tb_cp0_unit;

   localparam logic [31:0] PRID    = 32'h4D495053;
   localparam logic [31:0] EXC_VEC = 32'h0000_4180;

   logic        clk;
   logic        reset;
   logic [31:0] pc_i;
   logic        bd_i;
   logic        exc_valid_i;
   logic [4:0]  exc_code_i;
   logic [5:0]  hwint_i;
   logic        we_i;
   logic [4:0]  addr_i;
   logic [31:0] wdata_i;
   logic        eret_i;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_i;
`endif
   logic [31:0] rdata_o;
   logic        req_o;
   logic [31:0] vec_o;
   logic [31:0] epc_o;
   logic        exl_o;

   cp0_unit #(.PRID(PRID), .EXC_VEC(EXC_VEC)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_i       (pc_i),
      .bd_i       (bd_i),
      .exc_valid_i(exc_valid_i),
      .exc_code_i (exc_code_i),
      .hwint_i    (hwint_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .eret_i     (eret_i),
`ifdef CP0_BADVADDR_EN
      .badvaddr_i (badvaddr_i),
`endif
      .rdata_o    (rdata_o),
      .req_o      (req_o),
      .vec_o      (vec_o),
      .epc_o      (epc_o),
      .exl_o      (exl_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        bd;
      logic        ev;
      logic [4:0]  ec;
      logic [5:0]  hw;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wd;
      logic        eret;
      logic        req;
      logic        exl;
      logic [31:0] epc;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[$];
   int   n_vectors   = 0;
   int   n_checks    = 0;
   int   miscompares = 0;

   function automatic vec_t mk(string name, logic [31:0] pc, logic bd, logic ev,
                               logic [4:0] ec, logic [5:0] hw, logic we,
                               logic [4:0] addr, logic [31:0] wd, logic eret,
                               logic req, logic exl, logic [31:0] epc,
                               logic [31:0] rd);
      vec_t v;
      v.name = name; v.pc = pc; v.bd = bd; v.ev = ev; v.ec = ec; v.hw = hw;
      v.we = we; v.addr = addr; v.wd = wd; v.eret = eret;
      v.req = req; v.exl = exl; v.epc = epc; v.rd = rd;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      pc_i        = v.pc;
      bd_i        = v.bd;
      exc_valid_i = v.ev;
      exc_code_i  = v.ec;
      hwint_i     = v.hw;
      we_i        = v.we;
      addr_i      = v.addr;
      wdata_i     = v.wd;
      eret_i      = v.eret;
   endtask

   // Drive after a rising edge, sample on the following falling edge.
   task automatic apply(vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      n_vectors++;
      chk({v.name, ".req"},   {31'd0, req_o}, {31'd0, v.req});
      chk({v.name, ".exl"},   {31'd0, exl_o}, {31'd0, v.exl});
      chk({v.name, ".epc"},   epc_o, v.epc);
      chk({v.name, ".rdata"}, rdata_o, v.rd);
      chk({v.name, ".vec"},   vec_o, EXC_VEC);
      $display("vec %0d %s: req=%b exl=%b epc=%h rdata=%h", n_vectors, v.name,
               req_o, exl_o, epc_o, rdata_o);
   endtask

   initial begin
      //                name            pc        bd ev ec     hw       we addr   wdata          eret  req exl epc       rdata
      vecs.push_back(mk("rst_prid",     32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd15, 32'h0,         0,    0,  0,  32'h0,    PRID));
      vecs.push_back(mk("rst_sr",       32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0,    0,  0,  32'h0,    32'h0));
      vecs.push_back(mk("wr_sr_im0_ie", 32'h0,    0, 0, 5'd0,  6'b0,    1, 5'd12, 32'h0000_0401, 0,    0,  0,  32'h0,    32'h0));
      vecs.push_back(mk("rd_sr",        32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0,    0,  0,  32'h0,    32'h0000_0401));
      vecs.push_back(mk("irq_entry",    32'h3010, 0, 0, 5'd0,  6'b000001,0,5'd13, 32'h0,         0,    1,  0,  32'h0,    32'h0));
      vecs.push_back(mk("irq_epc",      32'h3010, 0, 0, 5'd0,  6'b000001,0,5'd14, 32'h0,         0,    0,  1,  32'h3010, 32'h3010));
      vecs.push_back(mk("irq_cause_ip", 32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0,    0,  1,  32'h3010, 32'h0000_0400));
      vecs.push_back(mk("exl_blocks_exc",32'h0,   0, 1, 5'd12, 6'b0,    0, 5'd12, 32'h0,         0,    0,  1,  32'h3010, 32'h0000_0403));
      vecs.push_back(mk("eret1",        32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         1,    0,  1,  32'h3010, 32'h3010));
      vecs.push_back(mk("ds_exc",       32'h3024, 1, 1, 5'd12, 6'b0,    0, 5'd12, 32'h0,         0,    1,  0,  32'h3010, 32'h0000_0401));
      vecs.push_back(mk("ds_cause",     32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0,    0,  1,  32'h3020, 32'h8000_0030));
      vecs.push_back(mk("wr_cause_ign", 32'h0,    0, 0, 5'd0,  6'b0,    1, 5'd13, 32'hFFFF_FFFF, 0,    0,  1,  32'h3020, 32'h8000_0030));
      vecs.push_back(mk("cause_kept",   32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0,    0,  1,  32'h3020, 32'h8000_0030));
      vecs.push_back(mk("eret2",        32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         1,    0,  1,  32'h3020, 32'h3020));
      vecs.push_back(mk("wr_sr_im1",    32'h0,    0, 0, 5'd0,  6'b0,    1, 5'd12, 32'h0000_0801, 0,    0,  0,  32'h3020, 32'h0000_0401));
      vecs.push_back(mk("mask_im",      32'h0,    0, 0, 5'd0,  6'b000001,0,5'd12, 32'h0,         0,    0,  0,  32'h3020, 32'h0000_0801));
      vecs.push_back(mk("wr_sr_ie0",    32'h0,    0, 0, 5'd0,  6'b000001,1,5'd12, 32'h0000_0400, 0,    0,  0,  32'h3020, 32'h0000_0801));
      vecs.push_back(mk("mask_ie",      32'h0,    0, 0, 5'd0,  6'b000001,0,5'd12, 32'h0,         0,    0,  0,  32'h3020, 32'h0000_0400));
      vecs.push_back(mk("wr_sr_ie1",    32'h0,    0, 0, 5'd0,  6'b0,    1, 5'd12, 32'h0000_0401, 0,    0,  0,  32'h3020, 32'h0000_0400));
      vecs.push_back(mk("irq_vs_exc",   32'h3050, 0, 1, 5'd10, 6'b000001,1,5'd12, 32'h0,         0,    1,  0,  32'h3020, 32'h0000_0401));
      vecs.push_back(mk("sr_wr_dropped",32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0,    0,  1,  32'h3050, 32'h0000_0403));
      vecs.push_back(mk("irq_code0",    32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd13, 32'h0,         0,    0,  1,  32'h3050, 32'h0));
      vecs.push_back(mk("wr_epc_bypass",32'h0,    0, 0, 5'd0,  6'b0,    1, 5'd14, 32'h0000_3047, 0,    0,  1,  32'h3044, 32'h3050));
      vecs.push_back(mk("eret_new_epc", 32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd14, 32'h0,         1,    0,  1,  32'h3044, 32'h3044));
      vecs.push_back(mk("exl_cleared",  32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd12, 32'h0,         0,    0,  0,  32'h3044, 32'h0000_0401));
      vecs.push_back(mk("rd_badva_pre", 32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd8,  32'h0,         0,    0,  0,  32'h3044, 32'h0));
      vecs.push_back(mk("rd_unmapped",  32'h0,    0, 0, 5'd0,  6'b0,    0, 5'd0,  32'h0,         0,    0,  0,  32'h3044, 32'h0));

      reset = 1'b1;
      drive(mk("idle", 32'h0, 0, 0, 5'd0, 6'b0, 0, 5'd0, 32'h0, 0, 0, 0, 32'h0, 32'h0));
`ifdef CP0_BADVADDR_EN
      badvaddr_i = 32'h0;
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Reset while EXL=1: take an interrupt, then reset with the line held.
      apply(mk("pre_rst_irq", 32'h3010, 0, 0, 5'd0, 6'b000001, 0, 5'd15, 32'h0, 0,
               1, 0, 32'h3044, PRID));
      apply(mk("pre_rst_exl", 32'h0, 0, 0, 5'd0, 6'b000001, 0, 5'd14, 32'h0, 0,
               0, 1, 32'h3010, 32'h3010));
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_vectors++;
      chk("rst_exl.req", {31'd0, req_o}, 32'd0);
      chk("rst_exl.exl", {31'd0, exl_o}, 32'd0);
      chk("rst_exl.epc", epc_o, 32'h0);
      $display("vec %0d rst_exl: req=%b exl=%b epc=%h", n_vectors, req_o, exl_o, epc_o);
      apply(mk("rst_sr_clr",    32'h0, 0, 0, 5'd0, 6'b0, 0, 5'd12, 32'h0, 0, 0, 0, 32'h0, 32'h0));
      apply(mk("rst_cause_clr", 32'h0, 0, 0, 5'd0, 6'b0, 0, 5'd13, 32'h0, 0, 0, 0, 32'h0, 32'h0));

`ifdef CP0_BADVADDR_EN
      // AdEL capture of the faulting address.
      @(posedge clk);
      #1;
      badvaddr_i = 32'h7F01;
      apply(mk("adel_entry", 32'h3100, 0, 1, 5'd4, 6'b0, 0, 5'd8, 32'h0, 0,
               1, 0, 32'h0, 32'h0));
      badvaddr_i = 32'h0;
      apply(mk("adel_badva", 32'h0, 0, 0, 5'd0, 6'b0, 0, 5'd8,  32'h0, 0, 0, 1, 32'h3100, 32'h7F01));
      apply(mk("adel_cause", 32'h0, 0, 0, 5'd0, 6'b0, 0, 5'd13, 32'h0, 0, 0, 1, 32'h3100, 32'h0000_0010));
      apply(mk("badva_ro",   32'h0, 0, 0, 5'd0, 6'b0, 1, 5'd8,  32'h1234, 0, 0, 1, 32'h3100, 32'h7F01));
      apply(mk("badva_kept", 32'h0, 0, 0, 5'd0, 6'b0, 0, 5'd8,  32'h0, 0, 0, 1, 32'h3100, 32'h7F01));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
      $finish;
   end

endmodule
